// File: rtl/fft_r4_input_reorder.sv
// Input stage of the radix-4 FFT: buffers one frame of N real samples, then drains it as
// N/4 stride-N/4 groups that map directly onto the first-stage butterfly inputs.
module fft_r4_input_reorder #(
    parameter int N      = 16,
    parameter int DATA_W = 32,
    localparam int G     = N / 4,
    localparam int WR_W  = $clog2(N),
    localparam int GRP_W = (G > 1) ? $clog2(G) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_a,
    output logic signed [DATA_W-1:0] out_b,
    output logic signed [DATA_W-1:0] out_c,
    output logic signed [DATA_W-1:0] out_d,
    output logic [GRP_W-1:0]         out_group,
    output logic                     out_last
);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [WR_W-1:0]  WR_LAST  = WR_W'(N - 1);
    localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(G - 1);
    localparam logic [WR_W-1:0]  OFF_B    = WR_W'(G);
    localparam logic [WR_W-1:0]  OFF_C    = WR_W'(2 * G);
    localparam logic [WR_W-1:0]  OFF_D    = WR_W'(3 * G);

    state_t                   state;
    logic [WR_W-1:0]          wr_cnt;
    logic [GRP_W-1:0]         rd_grp;
    logic signed [DATA_W-1:0] mem [N];
    logic [WR_W-1:0]          rd_base;
    logic                     in_fire;
    logic                     out_fire;
    logic                     wr_term;
    logic                     grp_term;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign wr_term  = (wr_cnt == WR_LAST);
    assign grp_term = (rd_grp == GRP_LAST);

    // in_ready and out_valid are registered copies of the next state, so both
    // flip on the same edge as the FILL/DRAIN transition and are low in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            wr_cnt    <= '0;
            rd_grp    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    if (in_fire) begin
                        if (wr_term) begin
                            wr_cnt    <= '0;
                            state     <= DRAIN;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    in_ready  <= 1'b0;
                    out_valid <= 1'b1;
                    if (out_fire) begin
                        if (grp_term) begin
                            rd_grp    <= '0;
                            state     <= FILL;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                        end else begin
                            rd_grp <= rd_grp + 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= FILL;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // in_ready is low throughout DRAIN, so the frame cannot be overwritten while it drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
        end else if (in_fire) begin
            mem[wr_cnt] <= in_data;
        end
    end

    assign rd_base   = WR_W'(rd_grp);
    assign out_a     = mem[rd_base];
    assign out_b     = mem[rd_base + OFF_B];
    assign out_c     = mem[rd_base + OFF_C];
    assign out_d     = mem[rd_base + OFF_D];
    assign out_group = rd_grp;
    assign out_last  = out_valid && grp_term;

endmodule
